// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the seven-segment scan controller.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [3:0] SS_MAX   = 4'd15;
    localparam logic       MODE_HEX = 1'b0;
    localparam logic       MODE_RAW = 1'b1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern {g..a}.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment controller with PWM brightness, leading-zero
// blanking, raw mode and frame-synchronous update. Optional lamp test: SEG7_LAMP_TEST_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int SUB_CNT = 3125
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   disp_num,
    input  logic [8*DIGITS-1:0]   raw_seg,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
`ifdef SEG7_LAMP_TEST_EN
    input  logic                  lamp_test,
`endif
    output logic [7:0]            SEGMENT,
    output logic [DIGITS-1:0]     AN,
    output logic                  frame_start
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = (SUB_CNT > 1) ? $clog2(SUB_CNT) : 1;

    logic [PRE_W-1:0] pre;
    logic [3:0]       ss;
    logic [IDX_W-1:0] idx;
    logic             pre_tc;
    logic             wrap;

    logic [4*DIGITS-1:0] shd_num, act_num;
    logic [8*DIGITS-1:0] shd_raw, act_raw;
    logic [DIGITS-1:0]   shd_dp, act_dp;
    logic                shd_mode, act_mode;
    logic                pend;

    logic [3:0]        cur_nib;
    logic [7:0]        cur_raw;
    logic              cur_dp;
    logic              cur_zero;
    logic [DIGITS-1:0] an_sel;
    logic              acc_zero;
    logic [6:0]        dec_seg;
    logic              lit;
    logic              lamp;
    logic [7:0]        seg_val;

    assign pre_tc = (pre == PRE_W'(SUB_CNT - 1));
    assign wrap   = pre_tc && (ss == SS_MAX) && (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            pre <= '0;
            ss  <= '0;
            idx <= '0;
        end else if (pre_tc) begin
            pre <= '0;
            ss  <= ss + 1'b1;
            if (ss == SS_MAX)
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // A load landing in the wrap cycle bypasses the shadow so it shows in the next frame.
    always_ff @(posedge clk) begin
        if (clr) begin
            shd_num  <= '0;
            shd_raw  <= '0;
            shd_dp   <= '0;
            shd_mode <= MODE_HEX;
            act_num  <= '0;
            act_raw  <= '0;
            act_dp   <= '0;
            act_mode <= MODE_HEX;
            pend     <= 1'b0;
        end else begin
            if (load) begin
                shd_num  <= disp_num;
                shd_raw  <= raw_seg;
                shd_dp   <= dp;
                shd_mode <= mode;
            end
            if (wrap) begin
                pend <= 1'b0;
                if (load) begin
                    act_num  <= disp_num;
                    act_raw  <= raw_seg;
                    act_dp   <= dp;
                    act_mode <= mode;
                end else if (pend) begin
                    act_num  <= shd_num;
                    act_raw  <= shd_raw;
                    act_dp   <= shd_dp;
                    act_mode <= shd_mode;
                end
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

    // Scanning from the top digit down accumulates "all higher nibbles are zero".
    always_comb begin
        cur_nib  = '0;
        cur_raw  = SEG_OFF;
        cur_dp   = 1'b0;
        cur_zero = 1'b0;
        an_sel   = '1;
        acc_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc_zero = acc_zero && (act_num[k*4 +: 4] == 4'd0);
            if (idx == IDX_W'(k)) begin
                cur_nib   = act_num[k*4 +: 4];
                cur_raw   = act_raw[k*8 +: 8];
                cur_dp    = act_dp[k];
                cur_zero  = acc_zero && (k != 0);
                an_sel[k] = 1'b0;
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

`ifdef SEG7_LAMP_TEST_EN
    assign lamp = lamp_test;
`else
    assign lamp = 1'b0;
`endif

    assign lit = lamp || (ss <= bright);

    always_comb begin
        seg_val = {~cur_dp, dec_seg};
        if (lamp)
            seg_val = 8'h00;
        else if (act_mode == MODE_RAW)
            seg_val = cur_raw;
        else if (blank_lz && cur_zero)
            seg_val = SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            AN          <= '1;
            SEGMENT     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            AN          <= lit ? an_sel : '1;
            SEGMENT     <= lit ? seg_val : SEG_OFF;
            frame_start <= wrap;
        end
    end

endmodule
